// File: rtl/ram_frame_snapshot.sv
// ram_frame_snapshot: once per vertical blank, copies DEPTH RAM bytes into a shadow
// bank over a shared read port, then swaps banks so VGA always sees a coherent frame.
module ram_frame_snapshot #(
  parameter int DEPTH       = 65,
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int BASE_ADDR   = 0,
  parameter int DISPLAY_IDX = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vblank_start,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic [6:0]    pix_idx,
  output logic [DW-1:0] pix_data,
  output logic [DW-1:0] display,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, SWAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] iss;
  logic [CW-1:0] wr;
  logic          vld_p1;
  logic          vis_sel;
  logic [1:0]    bank_ok;
  logic [DW-1:0] bank [2][DEPTH];
  logic          issue;
  logic          last_cap;

  assign issue    = (state == READ) && mem_gnt;
  assign last_cap = vld_p1 && (wr == CW'(DEPTH - 1));
  assign mem_req  = (state == READ);
  assign mem_addr = AW'(BASE_ADDR) + AW'(iss);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vblank_start) state_nxt = READ;
      READ:    if (issue && (iss == CW'(DEPTH - 1))) state_nxt = DRAIN;
      // Leave as soon as the final capture is landing so the swap follows directly.
      DRAIN:   if (last_cap || (wr == CW'(DEPTH))) state_nxt = SWAP;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss        <= '0;
      wr         <= '0;
      vld_p1     <= 1'b0;
      vis_sel    <= 1'b0;
      bank_ok    <= 2'b00;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vld_p1     <= issue;
      frame_done <= (state == SWAP);
      if ((state == IDLE) && vblank_start) begin
        iss <= '0;
        wr  <= '0;
      end else begin
        if (issue)  iss <= iss + 1'b1;
        if (vld_p1) wr  <= wr + 1'b1;
      end
      if (state == SWAP) begin
        vis_sel           <= ~vis_sel;
        bank_ok[~vis_sel] <= 1'b1;
        iss               <= '0;
      end
      if (vblank_start && (state != IDLE)) overrun <= 1'b1;
    end
  end

  // Stage p1: read data returns one cycle after issue and lands in the shadow bank.
  always_ff @(posedge clk) begin
    if (vld_p1 && !reset) bank[~vis_sel][wr] <= mem_rdata;
  end

  // Stage p1 (VGA side): registered reads of the visible bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_data <= '0;
      display  <= '0;
    end else begin
      pix_data <= (bank_ok[vis_sel] && (int'(pix_idx) < DEPTH)) ? bank[vis_sel][pix_idx] : '0;
      display  <= bank_ok[vis_sel] ? bank[vis_sel][DISPLAY_IDX] : '0;
    end
  end

endmodule

// File: tb/tb_ram_frame_snapshot.sv
// Directed bench for ram_frame_snapshot: a RAM responder, a frame-level reference
// model checked every cycle, and hand-computed literal expectations per scenario.
module tb_ram_frame_snapshot;

  localparam int DEPTH = 65;
  localparam int BASE  = 0;
  localparam int DIDX  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vblank_start = 1'b0;
  logic       mem_req;
  logic       mem_gnt = 1'b1;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [6:0] pix_idx = 7'd0;
  logic [7:0] pix_data;
  logic [7:0] display;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  ram_frame_snapshot #(
    .DEPTH(DEPTH), .AW(8), .DW(8), .BASE_ADDR(BASE), .DISPLAY_IDX(DIDX)
  ) dut (
    .clk(clk), .reset(reset), .vblank_start(vblank_start),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_idx(pix_idx), .pix_data(pix_data), .display(display),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_issued = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // RAM responder: data for a read issued in one cycle is presented in the next.
  logic [7:0] ram [256];
  logic       iss_n = 1'b0;
  logic [7:0] rd_n = 8'h00;

  always @(negedge clk) begin
    iss_n = mem_req && mem_gnt;
    rd_n  = ram[mem_addr];
    if (iss_n) n_issued++;
  end

  always @(posedge clk) begin
    #1;
    mem_rdata = iss_n ? rd_n : 8'($urandom);
  end

  // Frame-level reference model: counts grants, snapshots RAM at grant time,
  // and publishes the snapshot two cycles after the final grant.
  logic       m_known = 1'b0;
  logic       m_active = 1'b0;
  int         m_grants = 0;
  int         m_tail = 0;
  logic       m_done = 1'b0;
  logic       m_over = 1'b0;
  logic       m_vis_ok = 1'b0;
  logic [7:0] m_pix = 8'h00;
  logic [7:0] m_disp = 8'h00;
  logic [7:0] m_vis [DEPTH];
  logic [7:0] m_shadow [DEPTH];

  always @(negedge clk) begin
    logic       m_req;
    logic       was_active;
    logic       done_n;
    logic [7:0] new_pix;
    logic [7:0] new_disp;
    logic [7:0] a;
    m_req = m_active && (m_grants < DEPTH);
    a     = 8'(BASE + m_grants);
    if (m_known) begin
      chk("busy", {31'd0, busy}, {31'd0, m_active});
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
      if (m_req) chk("mem_addr", {24'd0, mem_addr}, {24'd0, a});
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
      chk("overrun", {31'd0, overrun}, {31'd0, m_over});
      chk("pix_data", {24'd0, pix_data}, {24'd0, m_pix});
      chk("display", {24'd0, display}, {24'd0, m_disp});
    end
    if (reset) begin
      m_known  = 1'b1;
      m_active = 1'b0;
      m_grants = 0;
      m_tail   = 0;
      m_done   = 1'b0;
      m_over   = 1'b0;
      m_vis_ok = 1'b0;
      m_pix    = 8'h00;
      m_disp   = 8'h00;
    end else if (m_known) begin
      new_pix  = (m_vis_ok && (int'(pix_idx) < DEPTH)) ? m_vis[pix_idx] : 8'h00;
      new_disp = m_vis_ok ? m_vis[DIDX] : 8'h00;
      was_active = m_active;
      done_n = 1'b0;
      if (m_active) begin
        if (m_req) begin
          if (mem_gnt) begin
            m_shadow[m_grants] = ram[a];
            m_grants++;
            if (m_grants == DEPTH) m_tail = 1;
          end
        end else if (m_tail == 2) begin
          for (int i = 0; i < DEPTH; i++) m_vis[i] = m_shadow[i];
          m_vis_ok = 1'b1;
          m_active = 1'b0;
          done_n   = 1'b1;
        end else begin
          m_tail++;
        end
      end
      if (vblank_start) begin
        if (was_active) m_over = 1'b1;
        else begin
          m_active = 1'b1;
          m_grants = 0;
          m_tail   = 0;
        end
      end
      m_pix  = new_pix;
      m_disp = new_disp;
      m_done = done_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one frame starting now. gmode 1 alternates grant 1,0 over the first 64 cycles.
  task automatic run_frame(input int gmode, input int vb2, output int lat, output int ndone,
                           output logic [7:0] pix_at, output logic [7:0] disp_at,
                           output logic [7:0] pix_after, output logic [7:0] disp_after);
    lat = -1;
    ndone = 0;
    pix_at = 8'h00; disp_at = 8'h00; pix_after = 8'h00; disp_after = 8'h00;
    mem_gnt = 1'b1;
    vblank_start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      tick(1);
      vblank_start = (n == vb2);
      mem_gnt = (gmode == 1 && n <= 64) ? ((n % 2) == 1) : 1'b1;
      if (frame_done) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          pix_at = pix_data;
          disp_at = display;
        end
      end
      if (lat > 0 && n == lat + 1) begin
        pix_after = pix_data;
        disp_after = display;
      end
      if (lat > 0 && n == lat + 6) break;
    end
    vblank_start = 1'b0;
    mem_gnt = 1'b1;
  endtask

  initial begin
    int lat, nd, found;
    logic [7:0] pa, da, pn, dn;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i + 1);

    tick(3);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_pix", {24'd0, pix_data}, 32'd0);
    chk("rst_disp", {24'd0, display}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_over", {31'd0, overrun}, 32'd0);

    pix_idx = 7'd10;
    tick(1);
    chk("nocopy_pix", {24'd0, pix_data}, 32'd0);
    chk("nocopy_disp", {24'd0, display}, 32'd0);

    n_issued = 0;
    run_frame(0, 0, lat, nd, pa, da, pn, dn);
    chk("t1_latency", lat, 68);
    chk("t1_ndone", nd, 1);
    chk("t1_issued", n_issued, 65);
    pix_idx = 7'd5;
    tick(1);
    chk("t1_pix5", {24'd0, pix_data}, 32'd6);
    chk("t1_display", {24'd0, display}, 32'd65);
    pix_idx = 7'd70;
    tick(1);
    chk("t2_pix70", {24'd0, pix_data}, 32'd0);

    n_issued = 0;
    run_frame(1, 0, lat, nd, pa, da, pn, dn);
    chk("t3_latency", lat, 100);
    chk("t3_issued", n_issued, 65);
    for (int i = 0; i < DEPTH; i++) begin
      pix_idx = 7'(i);
      tick(1);
      chk("t3_content", {24'd0, pix_data}, 32'(i + 1));
    end

    run_frame(0, 10, lat, nd, pa, da, pn, dn);
    chk("t5_latency", lat, 68);
    chk("t5_ndone", nd, 1);
    chk("t5_overrun", {31'd0, overrun}, 32'd1);

    ram[64] = 8'hAA;
    pix_idx = 7'd64;
    run_frame(0, 0, lat, nd, pa, da, pn, dn);
    chk("t4a_pix", {24'd0, pn}, 32'hAA);
    ram[64] = 8'h55;
    run_frame(0, 0, lat, nd, pa, da, pn, dn);
    chk("t4_pix_at_done", {24'd0, pa}, 32'hAA);
    chk("t4_disp_at_done", {24'd0, da}, 32'hAA);
    chk("t4_pix_after", {24'd0, pn}, 32'h55);
    chk("t4_disp_after", {24'd0, dn}, 32'h55);

    mem_gnt = 1'b1;
    vblank_start = 1'b1;
    tick(1);
    vblank_start = 1'b0;
    found = 0;
    for (int n = 0; n < 100; n++) begin
      if (mem_req && mem_addr == 8'd30) begin
        found = 1;
        break;
      end
      tick(1);
    end
    chk("t6_reach30", found, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_req", {31'd0, mem_req}, 32'd0);
    chk("t6_addr", {24'd0, mem_addr}, 32'd0);
    chk("t6_pix", {24'd0, pix_data}, 32'd0);
    chk("t6_over", {31'd0, overrun}, 32'd0);
    pix_idx = 7'd5;
    tick(1);
    chk("t6_bank_invalid", {24'd0, pix_data}, 32'd0);
    vblank_start = 1'b1;
    tick(1);
    vblank_start = 1'b0;
    chk("t6_restart_req", {31'd0, mem_req}, 32'd1);
    chk("t6_restart_addr", {24'd0, mem_addr}, 32'd0);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      tick(1);
      if (frame_done) begin
        lat = n + 1;
        break;
      end
    end
    chk("t6_latency", lat, 68);
    tick(2);
    chk("t6_pix5", {24'd0, pix_data}, 32'd6);
    chk("t6_display", {24'd0, display}, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
